iob_timer_mc: RTL and testbench
===============================

Name: iob_timer_mc

Overview:
Multi-channel successor to the single 64-bit free-running timer core. It has one shared programmable prescaler and N_CH independent counters. Each counter has its own enable, soft reset, compare value, mode (free-run / periodic / one-shot), snapshot register and sticky interrupt flag. It sits behind the timer software-register block: registers drive the *_i controls, and the *_o signals are read back or routed to the interrupt controller.

Parameters:
N_CH, 2, number of independent counter channels (1..16)
CNT_W, 64, width of each channel counter, compare value and snapshot (8..64)
PRESC_W, 16, width of the shared prescaler divide value

Ports:
clk_i  input  1  system clock
arst_n_i  input  1  asynchronous active-low reset
cke_i  input  1  clock enable; when low, all state is frozen
enable_i  input  1  global enable; gates the prescaler
presc_i  input  PRESC_W  divide value; tick period = presc_i+1 cycles
ch_en_i  input  N_CH  per-channel count enable
ch_rst_i  input  N_CH  per-channel synchronous counter reset/re-arm
ch_mode_i  input  2*N_CH  per-channel mode: 00 free-run, 01 periodic, 10 one-shot, 11 treated as 00
ch_cmp_i  input  CNT_W*N_CH  per-channel compare value
ch_sample_i  input  N_CH  per-channel snapshot strobe
irq_clr_i  input  N_CH  per-channel interrupt-flag clear
ch_value_o  output  CNT_W*N_CH  per-channel snapshot register
ch_irq_o  output  N_CH  per-channel sticky interrupt flag
ch_done_o  output  N_CH  one-shot expired (counter halted)
tick_o  output  1  prescaler tick pulse, 1 cycle

Behaviour:
- Reset (arst_n_i=0, async): prescaler counter, all channel counters, ch_value_o, ch_irq_o, ch_done_o and tick_o are 0.
- cke_i=0: no register changes; outputs hold.
- Prescaler (only while enable_i=1):
  - p_cnt increments each cycle.
  - When p_cnt >= presc_i, tick is asserted for that cycle and p_cnt returns to 0 on the next edge. The >= comparison makes a live decrease of presc_i safe.
  - presc_i=0 gives a tick every cycle.
  - enable_i=0: p_cnt holds and there is no tick.
  - tick_o is registered: it goes high the cycle after the tick condition, for one cycle.
- Channel i on a tick with ch_en_i[i]=1 and ch_done_o[i]=0:
  - Free-run: cnt <= cnt+1 and wraps from all-ones to 0. The wrap sets irq[i].
  - Periodic: if cnt == cmp then cnt <= 0 and irq[i] is set; else cnt+1. cmp=0 means irq on every tick and cnt stays 0.
  - One-shot: if cnt == cmp then cnt holds, irq[i] is set and done[i] <= 1; else cnt+1. Once done, the counter stops until ch_rst_i[i]. cmp=0 means done on the first tick.
  - Compare is against the live ch_cmp_i. If cmp is lowered below cnt, the counter runs on to wrap, and periodic/one-shot match at cmp on the next pass.
- ch_en_i[i]=0: counter holds and irq/done are unchanged.
- ch_rst_i[i]=1: cnt <= 0 and done[i] <= 0 on the next edge. This has priority over any tick in the same cycle and is independent of enable_i and ch_en_i. irq[i] is unaffected.
- Mode change while counting takes effect on the next tick. Changing into one-shot does not clear done.
- Interrupt flag:
  - Set/clear priority: a set in the same cycle as irq_clr_i[i] wins, so the flag stays 1.
  - Otherwise irq_clr_i[i] clears it on the next edge.
- Snapshot:
  - ch_sample_i[i]=1: ch_value_o[i] <= the counter value present in that cycle, before any same-cycle increment. It is visible 1 cycle later.
  - Without a strobe, ch_value_o holds.
  - Asserting all bits in one cycle gives a coherent multi-channel capture.
- Arithmetic: all counter arithmetic is unsigned, modulo 2^CNT_W.
- Channels share only the tick and never interact otherwise.
- No combinational path from any input to any output; every output is a register.

Test Plan:
- Reset & prescale: hold arst_n_i low, then release. Set presc_i=3, enable_i=1, ch0 free-run, ch_en=1, run 40 cycles, sample ch0 -> ch_value_o[0]=10 (±1 depending on phase), tick_o every 4th cycle, all outputs 0 during reset.
- Periodic: presc_i=0, ch1 periodic with cmp=4 -> count sequence 0,1,2,3,4,0,…; irq[1] rises after the first 4→0 transition. Assert irq_clr_i[1] on the same cycle as the next match -> irq stays 1. Clear on a non-match cycle -> irq goes to 0.
- One-shot: presc_i=0, ch0 one-shot with cmp=5 -> cnt halts at 5, done=1, irq=1 and cnt stays 5 for 20 cycles. Pulse ch_rst_i[0] -> cnt=0, done=0, counting resumes and irq stays 1.
- Wrap: CNT_W=8, free-run, force the counter to 0xFF via repeated ticks -> the next tick gives cnt=0x00 and irq=1.
- Priority/freeze: ch_rst_i together with a tick -> cnt=0. cke_i=0 for 10 cycles -> counters and prescaler unchanged. Change presc_i from 10 to 2 while p_cnt=7 -> tick on the next cycle, then a period of 3.
- Async reset mid-count: assert arst_n_i low between clock edges while the counters are nonzero -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/iob_timer_mc.sv
// Multi-channel timer: one shared prescaler feeding N_CH independent counters.
// Each channel supports free-run, periodic and one-shot modes with snapshot and sticky irq.
module iob_timer_mc #(
  parameter int N_CH    = 2,
  parameter int CNT_W   = 64,
  parameter int PRESC_W = 16
) (
  input  logic                  clk_i,
  input  logic                  arst_n_i,
  input  logic                  cke_i,
  input  logic                  enable_i,
  input  logic [PRESC_W-1:0]    presc_i,
  input  logic [N_CH-1:0]       ch_en_i,
  input  logic [N_CH-1:0]       ch_rst_i,
  input  logic [2*N_CH-1:0]     ch_mode_i,
  input  logic [CNT_W*N_CH-1:0] ch_cmp_i,
  input  logic [N_CH-1:0]       ch_sample_i,
  input  logic [N_CH-1:0]       irq_clr_i,
  output logic [CNT_W*N_CH-1:0] ch_value_o,
  output logic [N_CH-1:0]       ch_irq_o,
  output logic [N_CH-1:0]       ch_done_o,
  output logic                  tick_o
);

  logic [PRESC_W-1:0] p_cnt;
  logic               tick;
  logic               tick_q;

  // >= keeps the divider safe when presc_i drops below p_cnt
  assign tick = enable_i && (p_cnt >= presc_i);

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      p_cnt  <= '0;
      tick_q <= 1'b0;
    end else if (cke_i) begin
      tick_q <= tick;
      if (enable_i)
        p_cnt <= tick ? '0 : p_cnt + 1'b1;
    end
  end

  assign tick_o = tick_q;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic [CNT_W-1:0] val;
    logic [CNT_W-1:0] cmp;
    logic [1:0]       mode;
    logic             irq;
    logic             done;
    logic             done_n;
    logic             set;

    assign mode = ch_mode_i[2*g +: 2];
    assign cmp  = ch_cmp_i[CNT_W*g +: CNT_W];

    always_comb begin
      cnt_n  = cnt;
      done_n = done;
      set    = 1'b0;
      if (ch_rst_i[g]) begin
        cnt_n  = '0;
        done_n = 1'b0;
      end else if (tick && ch_en_i[g] && !done) begin
        unique case (mode)
          2'b01: begin
            if (cnt == cmp) begin
              cnt_n = '0;
              set   = 1'b1;
            end else begin
              cnt_n = cnt + 1'b1;
            end
          end
          2'b10: begin
            if (cnt == cmp) begin
              done_n = 1'b1;
              set    = 1'b1;
            end else begin
              cnt_n = cnt + 1'b1;
            end
          end
          default: begin
            cnt_n = cnt + 1'b1;
            set   = &cnt;
          end
        endcase
      end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
        cnt  <= '0;
        val  <= '0;
        irq  <= 1'b0;
        done <= 1'b0;
      end else if (cke_i) begin
        cnt  <= cnt_n;
        done <= done_n;
        irq  <= set | (irq & ~irq_clr_i[g]);
        if (ch_sample_i[g])
          val <= cnt;
      end
    end

    assign ch_value_o[CNT_W*g +: CNT_W] = val;
    assign ch_irq_o[g]  = irq;
    assign ch_done_o[g] = done;
  end

endmodule

// File: tb/tb_iob_timer_mc.sv
// Self-checking bench for iob_timer_mc (2 channels, 8-bit counters).
// Randomized and directed scenarios compared against a behavioural model.
module tb_iob_timer_mc;

  localparam int N  = 2;
  localparam int W  = 8;
  localparam int PW = 16;

  logic            clk = 1'b0;
  logic            arst_n;
  logic            cke;
  logic            en;
  logic [PW-1:0]   presc;
  logic [N-1:0]    ch_en;
  logic [N-1:0]    ch_rst;
  logic [2*N-1:0]  ch_mode;
  logic [W*N-1:0]  ch_cmp;
  logic [N-1:0]    sample;
  logic [N-1:0]    clr;
  logic [W*N-1:0]  value;
  logic [N-1:0]    irq;
  logic [N-1:0]    done;
  logic            tick;

  int checks = 0;
  int failures = 0;

  int mp;
  int mcnt[N];
  int mval[N];
  bit mirq[N];
  bit mdone[N];
  bit mtick;

  iob_timer_mc #(.N_CH(N), .CNT_W(W), .PRESC_W(PW)) dut (
    .clk_i(clk), .arst_n_i(arst_n), .cke_i(cke), .enable_i(en),
    .presc_i(presc), .ch_en_i(ch_en), .ch_rst_i(ch_rst),
    .ch_mode_i(ch_mode), .ch_cmp_i(ch_cmp), .ch_sample_i(sample),
    .irq_clr_i(clr), .ch_value_o(value), .ch_irq_o(irq),
    .ch_done_o(done), .tick_o(tick)
  );

  always #5 clk = ~clk;

  function automatic logic [W*N-1:0] ev();
    return {mval[1][W-1:0], mval[0][W-1:0]};
  endfunction

  function automatic logic [N-1:0] ei();
    return {mirq[1], mirq[0]};
  endfunction

  function automatic logic [N-1:0] ed();
    return {mdone[1], mdone[0]};
  endfunction

  task automatic reset_model();
    mp = 0;
    mtick = 0;
    for (int i = 0; i < N; i++) begin
      mcnt[i] = 0; mval[i] = 0; mirq[i] = 0; mdone[i] = 0;
    end
  endtask

  // Advance one clock; model computes the next state from the spec rules
  task automatic step();
    int ncnt[N];
    int nval[N];
    bit nirq[N];
    bit ndone[N];
    int np;
    bit ntick;
    bit tk;
    np = mp;
    ntick = mtick;
    for (int i = 0; i < N; i++) begin
      ncnt[i] = mcnt[i]; nval[i] = mval[i];
      nirq[i] = mirq[i]; ndone[i] = mdone[i];
    end
    if (cke) begin
      tk = en && (mp >= int'(presc));
      ntick = tk;
      if (en) np = tk ? 0 : mp + 1;
      for (int i = 0; i < N; i++) begin
        int md;
        int cv;
        bit s;
        md = int'(ch_mode[2*i +: 2]);
        cv = int'(ch_cmp[W*i +: W]);
        s = 0;
        if (sample[i]) nval[i] = mcnt[i];
        if (ch_rst[i]) begin
          ncnt[i] = 0;
          ndone[i] = 0;
        end else if (tk && ch_en[i] && !mdone[i]) begin
          if (md == 1) begin
            if (mcnt[i] == cv) begin ncnt[i] = 0; s = 1; end
            else ncnt[i] = (mcnt[i] + 1) % 256;
          end else if (md == 2) begin
            if (mcnt[i] == cv) begin ndone[i] = 1; s = 1; end
            else ncnt[i] = (mcnt[i] + 1) % 256;
          end else begin
            ncnt[i] = (mcnt[i] + 1) % 256;
            s = (mcnt[i] == 255);
          end
        end
        nirq[i] = s ? 1'b1 : (clr[i] ? 1'b0 : mirq[i]);
      end
    end
    @(posedge clk);
    #1;
    mp = np;
    mtick = ntick;
    for (int i = 0; i < N; i++) begin
      mcnt[i] = ncnt[i]; mval[i] = nval[i];
      mirq[i] = nirq[i]; mdone[i] = ndone[i];
    end
  endtask

  task automatic clear_chans();
    ch_rst = '1;
    clr = '1;
    step();
    ch_rst = '0;
    clr = '0;
  endtask

  task automatic test_reset();
    arst_n = 0;
    reset_model();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (value !== '0) begin
      failures++;
      $display("FAIL reset_value got=%h exp=0", value);
    end
    checks++;
    if (irq !== '0 || done !== '0 || tick !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags got irq=%b done=%b tick=%b exp=0", irq, done, tick);
    end
    arst_n = 1;
  endtask

  task automatic test_prescale();
    presc = 3;
    en = 1;
    ch_mode = 4'b0000;
    ch_en = 2'b01;
    for (int k = 0; k < 40; k++) begin
      step();
      checks++;
      if (tick !== mtick) begin
        failures++;
        $display("FAIL presc_tick k=%0d got=%b exp=%b", k, tick, mtick);
      end
    end
    sample = 2'b01;
    step();
    sample = 0;
    checks++;
    if (value !== ev() || value[7:0] < 9 || value[7:0] > 11) begin
      failures++;
      $display("FAIL presc_count got=%0d exp=%0d", value[7:0], mval[0]);
    end
  endtask

  task automatic test_periodic();
    presc = 0;
    ch_en = 2'b10;
    ch_mode = 4'b0100;
    ch_cmp = {8'd4, 8'd0};
    clear_chans();
    sample = 2'b10;
    for (int k = 0; k < 12; k++) begin
      bit exp_irq;
      clr = (k == 9 || k == 10) ? 2'b10 : 2'b00;
      step();
      exp_irq = (k >= 4 && k <= 9);
      checks++;
      if (value[15:8] !== 8'(k % 5) || value !== ev()) begin
        failures++;
        $display("FAIL periodic_seq k=%0d got=%0d exp=%0d", k, value[15:8], k % 5);
      end
      checks++;
      if (irq[1] !== exp_irq || irq !== ei()) begin
        failures++;
        $display("FAIL periodic_irq k=%0d got=%b exp=%b", k, irq[1], exp_irq);
      end
    end
    sample = 0;
    clr = 0;
  endtask

  task automatic test_oneshot();
    presc = 0;
    ch_en = 2'b01;
    ch_mode = 4'b0010;
    ch_cmp = {8'd0, 8'd5};
    clear_chans();
    sample = 2'b01;
    for (int k = 0; k < 26; k++) begin
      step();
      checks++;
      if (value[7:0] !== 8'((k < 5) ? k : 5) || done[0] !== (k >= 5)) begin
        failures++;
        $display("FAIL oneshot k=%0d got=%0d/%b exp=%0d/%b", k, value[7:0], done[0],
                 (k < 5) ? k : 5, k >= 5);
      end
    end
    ch_rst = 2'b01;
    step();
    ch_rst = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (value[7:0] !== 8'(k) || done[0] !== 1'b0 || irq[0] !== 1'b1
          || value !== ev()) begin
        failures++;
        $display("FAIL oneshot_rearm k=%0d got=%0d/%b/%b exp=%0d/0/1", k,
                 value[7:0], done[0], irq[0], k);
      end
    end
    sample = 0;
  endtask

  task automatic test_wrap();
    presc = 0;
    ch_en = 2'b01;
    ch_mode = 4'b0000;
    clear_chans();
    repeat (255) step();
    sample = 2'b01;
    step();
    checks++;
    if (value[7:0] !== 8'hFF || irq[0] !== 1'b1) begin
      failures++;
      $display("FAIL wrap_edge got=%h/%b exp=ff/1", value[7:0], irq[0]);
    end
    step();
    sample = 0;
    checks++;
    if (value[7:0] !== 8'h00 || value !== ev()) begin
      failures++;
      $display("FAIL wrap_zero got=%h exp=00", value[7:0]);
    end
  endtask

  task automatic test_priority();
    logic [W*N-1:0] v0;
    logic [N-1:0] i0;
    int guard;
    presc = 0;
    ch_en = 2'b01;
    ch_mode = 0;
    repeat (5) step();
    ch_rst = 2'b01;
    step();
    ch_rst = 0;
    ch_en = 0;
    sample = 2'b01;
    step();
    sample = 0;
    checks++;
    if (value[7:0] !== 8'h00) begin
      failures++;
      $display("FAIL rst_over_tick got=%h exp=00", value[7:0]);
    end
    ch_en = 2'b11;
    repeat (3) step();
    v0 = value;
    i0 = irq;
    cke = 0;
    for (int k = 0; k < 10; k++) begin
      sample = 2'($urandom);
      clr = 2'($urandom);
      ch_rst = 2'($urandom);
      step();
    end
    checks++;
    if (value !== v0 || irq !== i0 || value !== ev() || irq !== ei()) begin
      failures++;
      $display("FAIL cke_freeze got=%h/%b exp=%h/%b", value, irq, v0, i0);
    end
    cke = 1;
    sample = 0;
    clr = 0;
    ch_rst = 0;
    presc = 10;
    guard = 0;
    while (mp != 7 && guard < 40) begin
      step();
      guard++;
    end
    checks++;
    if (guard >= 40) begin
      failures++;
      $display("FAIL presc_wait got=timeout exp=p_cnt7");
    end
    presc = 2;
    step();
    checks++;
    if (tick !== 1'b1) begin
      failures++;
      $display("FAIL presc_lower got=%b exp=1", tick);
    end
    for (int j = 0; j < 6; j++) begin
      step();
      checks++;
      if (tick !== (j % 3 == 2) || tick !== mtick) begin
        failures++;
        $display("FAIL presc_period j=%0d got=%b exp=%b", j, tick, j % 3 == 2);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 500; k++) begin
      cke = ($urandom_range(9) != 0);
      en = ($urandom_range(7) != 0);
      presc = PW'($urandom_range(3));
      ch_en = 2'($urandom);
      ch_rst = ($urandom_range(15) == 0) ? 2'($urandom) : 2'b00;
      if (k % 50 == 0) ch_mode = 4'($urandom);
      ch_cmp = {8'($urandom_range(15)), 8'($urandom_range(15))};
      sample = 2'($urandom);
      clr = ($urandom_range(7) == 0) ? 2'($urandom) : 2'b00;
      step();
      checks++;
      if (value !== ev() || irq !== ei() || done !== ed() || tick !== mtick) begin
        failures++;
        $display("FAIL random k=%0d got=%h/%b/%b/%b exp=%h/%b/%b/%b", k,
                 value, irq, done, tick, ev(), ei(), ed(), mtick);
      end
    end
    cke = 1;
    ch_rst = 0;
    clr = 0;
  endtask

  task automatic test_async_reset();
    en = 1;
    presc = 0;
    ch_en = 2'b11;
    ch_mode = 0;
    sample = 2'b11;
    repeat (6) step();
    sample = 0;
    #2;
    arst_n = 0;
    #1;
    reset_model();
    checks++;
    if (value !== '0 || irq !== '0 || done !== '0 || tick !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got=%h/%b/%b/%b exp=0", value, irq, done, tick);
    end
    #2;
    arst_n = 1;
    sample = 2'b11;
    step();
    step();
    sample = 0;
    checks++;
    if (value !== ev()) begin
      failures++;
      $display("FAIL after_reset got=%h exp=%h", value, ev());
    end
  endtask

  initial begin
    arst_n = 0; cke = 1; en = 0; presc = 0;
    ch_en = 0; ch_rst = 0; ch_mode = 0; ch_cmp = 0;
    sample = 0; clr = 0;
    test_reset();
    test_prescale();
    test_periodic();
    test_oneshot();
    test_wrap();
    test_priority();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
